// File: rtl/match_pkg.sv
// Shared types and constants for the pong match controller.
package match_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SERVE,
        RALLY,
        PAUSE,
        OVER
    } match_state_t;

    localparam logic [1:0] WON_NONE = 2'd0;
    localparam logic [1:0] WON_P1   = 2'd1;
    localparam logic [1:0] WON_P2   = 2'd2;

    localparam int FRAME_W = 8;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse for a raw push button.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic sync1, sync2, prev;
    logic valid1, valid2;

    // prev resets high and only tracks sync2 once sync2 holds a real sample,
    // so a button already held when reset releases never reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b1;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            valid1 <= 1'b1;
            valid2 <= valid1;
            prev   <= valid2 ? sync2 : 1'b1;
            rise   <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/match_ctl.sv
// Pong match sequencer: serve wait, rally, post-point pause, game over.
// Define MATCH_CTL_WIN_BY_TWO_EN to require a two-point lead with deuce folding.
module match_ctl
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic         clk65MHz,
    input  logic         rst,
    input  logic         end_of_frame,
    input  logic         serve,
    input  logic         screen_idle,
    input  logic         point_p1,
    input  logic         point_p2,
    output logic [3:0]   points_player_1,
    output logic [3:0]   points_player_2,
    output logic [1:0]   who_won,
    output logic         serve_go,
    output logic         freeze,
    output match_state_t dbg_state
);

    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic [3:0]         WIN_M1     = 4'(WIN_SCORE - 1);
    localparam logic [FRAME_W-1:0] PAUSE_LAST = FRAME_W'(PAUSE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] OVER_LAST  = FRAME_W'(OVER_FRAMES - 1);

    match_state_t       state, state_next;
    logic [FRAME_W-1:0] frame_cnt;
    logic               serve_rise;
    logic [4:0]         p1_inc, p2_inc;
    logic               p1_only, p2_only;
    logic               p1_wins, p2_wins, p1_ties, p2_ties;
    logic               pause_done, over_done;
    logic [3:0]         p1_next, p2_next;
    logic [1:0]         won_next;
    logic               go_next, freeze_next;

    btn_edge u_serve_edge (
        .clk  (clk65MHz),
        .rst  (rst),
        .btn  (serve),
        .rise (serve_rise)
    );

    assign p1_inc  = {1'b0, points_player_1} + 5'd1;
    assign p2_inc  = {1'b0, points_player_2} + 5'd1;
    assign p1_only = point_p1 & ~point_p2;
    assign p2_only = point_p2 & ~point_p1;

`ifdef MATCH_CTL_WIN_BY_TWO_EN
    assign p1_wins = (p1_inc >= {1'b0, WIN}) && (p1_inc >= {1'b0, points_player_2} + 5'd2);
    assign p2_wins = (p2_inc >= {1'b0, WIN}) && (p2_inc >= {1'b0, points_player_1} + 5'd2);
    assign p1_ties = (p1_inc == {1'b0, WIN}) && (points_player_2 == WIN);
    assign p2_ties = (p2_inc == {1'b0, WIN}) && (points_player_1 == WIN);
`else
    assign p1_wins = (p1_inc == {1'b0, WIN});
    assign p2_wins = (p2_inc == {1'b0, WIN});
    assign p1_ties = 1'b0;
    assign p2_ties = 1'b0;
`endif

    assign pause_done = (state == PAUSE) && end_of_frame && (frame_cnt == PAUSE_LAST);
    assign over_done  = (state == OVER)  && end_of_frame && (frame_cnt == OVER_LAST);
    assign dbg_state  = state;

    // State, registered outputs and the frame counter, which clears on every state change.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state           <= IDLE;
            points_player_1 <= '0;
            points_player_2 <= '0;
            who_won         <= WON_NONE;
            serve_go        <= 1'b0;
            freeze          <= 1'b1;
            frame_cnt       <= '0;
        end else begin
            state           <= state_next;
            points_player_1 <= p1_next;
            points_player_2 <= p2_next;
            who_won         <= won_next;
            serve_go        <= go_next;
            freeze          <= freeze_next;
            if (state_next != state)
                frame_cnt <= '0;
            else if ((state == PAUSE || state == OVER) && end_of_frame && frame_cnt != '1)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = WAIT_SERVE;
            WAIT_SERVE: if (serve_rise) state_next = RALLY;
            RALLY: begin
                if (point_p1 && point_p2) state_next = PAUSE;
                else if (p1_only)         state_next = p1_wins ? OVER : PAUSE;
                else if (p2_only)         state_next = p2_wins ? OVER : PAUSE;
            end
            PAUSE:      if (pause_done) state_next = WAIT_SERVE;
            OVER:       if (over_done)  state_next = WAIT_SERVE;
            default:    state_next = IDLE;
        endcase
        if (screen_idle) state_next = IDLE;
    end

    always_comb begin
        p1_next     = points_player_1;
        p2_next     = points_player_2;
        won_next    = who_won;
        go_next     = 1'b0;
        freeze_next = (state_next != RALLY);
        case (state)
            IDLE: begin
                p1_next  = '0;
                p2_next  = '0;
                won_next = WON_NONE;
            end
            WAIT_SERVE: go_next = serve_rise;
            RALLY: begin
                if (p1_only) begin
                    if (p1_ties) begin
                        p1_next = WIN_M1;
                        p2_next = WIN_M1;
                    end else begin
                        p1_next = p1_inc[3:0];
                        if (p1_wins) won_next = WON_P1;
                    end
                end else if (p2_only) begin
                    if (p2_ties) begin
                        p1_next = WIN_M1;
                        p2_next = WIN_M1;
                    end else begin
                        p2_next = p2_inc[3:0];
                        if (p2_wins) won_next = WON_P2;
                    end
                end
            end
            OVER: begin
                if (over_done) begin
                    p1_next  = '0;
                    p2_next  = '0;
                    won_next = WON_NONE;
                end
            end
            default: ;
        endcase
        if (screen_idle) begin
            p1_next  = '0;
            p2_next  = '0;
            won_next = WON_NONE;
            go_next  = 1'b0;
        end
    end

endmodule
